// File: rtl/dial_quad_gen_if.sv
// Control and dial signals between the joystick decode and one dial_quad_gen instance.
interface dial_quad_gen_if;
    logic       enable;
    logic       pause;
    logic       inc;
    logic       dec;
    logic       invert;
    logic [1:0] dial;
    logic       moving;

    modport master (output enable, pause, inc, dec, invert, input dial, moving);
    modport slave  (input enable, pause, inc, dec, invert, output dial, moving);
endinterface

// File: rtl/dial_quad_gen.sv
// Joystick up/down to gray-code quadrature dial sequencer; one instance per player.
// Define DIAL_ACCEL_EN to shorten the step period while a direction is held.
module dial_quad_gen #(
    parameter int PRESCALE     = 12000,
    parameter int START_PERIOD = 8
`ifdef DIAL_ACCEL_EN
    ,
    parameter int MIN_PERIOD   = 2,
    parameter int ACCEL_STEPS  = 4
`endif
) (
    input  logic           clk_sys,
    input  logic           reset_n,
    dial_quad_gen_if.slave bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = $clog2(START_PERIOD + 1);
`ifdef DIAL_ACCEL_EN
    localparam int SW = (ACCEL_STEPS > 1) ? $clog2(ACCEL_STEPS) : 1;
`endif

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_pre;
    logic          r_inc, r_dec, r_inv;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_dir, w_dir_nxt;
    logic [1:0]    r_phase, w_phase_nxt;
    logic [1:0]    r_dial;
    logic          w_tick, w_req, w_fwd, w_bwd, w_hold, w_step;
`ifdef DIAL_ACCEL_EN
    logic [CW-1:0] r_period, w_period_nxt;
    logic [SW-1:0] r_scnt, w_scnt_nxt;
`endif

    function automatic logic [1:0] gray(input logic [1:0] p);
        case (p)
            2'd0:    gray = 2'b11;
            2'd1:    gray = 2'b01;
            2'd2:    gray = 2'b00;
            default: gray = 2'b10;
        endcase
    endfunction

    // Millisecond tick; the prescaler stops with the CPU so pause keeps timing exact.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_pre <= '0;
        else if (!bus.pause)
            r_pre <= (r_pre == PW'(PRESCALE - 1)) ? '0 : r_pre + 1'b1;
    end

    assign w_tick = (r_pre == PW'(PRESCALE - 1)) && !bus.pause;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_inc <= 1'b0;
            r_dec <= 1'b0;
            r_inv <= 1'b0;
        end else if (!bus.pause) begin
            r_inc <= bus.inc;
            r_dec <= bus.dec;
            r_inv <= bus.invert;
        end
    end

    // Both buttons together cancel; invert swaps the sense of a single press.
    assign w_req  = r_inc ^ r_dec;
    assign w_fwd  = w_req & (r_inc ^ r_inv);
    assign w_bwd  = w_req & ~(r_inc ^ r_inv);
    assign w_hold = r_dir ? w_fwd : w_bwd;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else if (!bus.enable)
            r_state <= ST_IDLE;
        else if (!bus.pause)
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_dir_nxt    = r_dir;
        w_step       = 1'b0;
`ifdef DIAL_ACCEL_EN
        w_period_nxt = r_period;
        w_scnt_nxt   = r_scnt;
`endif
        case (r_state)
            ST_IDLE: begin
`ifdef DIAL_ACCEL_EN
                w_period_nxt = CW'(START_PERIOD);
                w_scnt_nxt   = '0;
`endif
                if (w_fwd | w_bwd) begin
                    w_step      = 1'b1;
                    w_dir_nxt   = w_fwd;
                    w_cnt_nxt   = CW'(START_PERIOD);
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A reversal drops through IDLE so the opposite step is a fresh press.
                if (!w_hold) begin
                    w_state_nxt = ST_IDLE;
`ifdef DIAL_ACCEL_EN
                    w_period_nxt = CW'(START_PERIOD);
                    w_scnt_nxt   = '0;
`endif
                end else if (w_tick) begin
                    if (r_cnt <= CW'(1)) begin
                        w_step = 1'b1;
`ifdef DIAL_ACCEL_EN
                        if (r_scnt == SW'(ACCEL_STEPS - 1)) begin
                            w_scnt_nxt = '0;
                            if (r_period > CW'(MIN_PERIOD))
                                w_period_nxt = r_period - 1'b1;
                        end else begin
                            w_scnt_nxt = r_scnt + 1'b1;
                        end
                        w_cnt_nxt = w_period_nxt;
`else
                        w_cnt_nxt = CW'(START_PERIOD);
`endif
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_phase_nxt = w_step ? (w_dir_nxt ? r_phase + 2'd1 : r_phase - 2'd1) : r_phase;

    // Phase survives IDLE so the dial never glitches; only disable rewinds it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_phase  <= 2'd0;
            r_dial   <= 2'b11;
            r_cnt    <= CW'(START_PERIOD);
            r_dir    <= 1'b1;
`ifdef DIAL_ACCEL_EN
            r_period <= CW'(START_PERIOD);
            r_scnt   <= '0;
`endif
        end else if (!bus.enable) begin
            r_phase  <= 2'd0;
            r_dial   <= 2'b11;
            r_cnt    <= CW'(START_PERIOD);
`ifdef DIAL_ACCEL_EN
            r_period <= CW'(START_PERIOD);
            r_scnt   <= '0;
`endif
        end else if (!bus.pause) begin
            r_phase  <= w_phase_nxt;
            r_dial   <= gray(w_phase_nxt);
            r_cnt    <= w_cnt_nxt;
            r_dir    <= w_dir_nxt;
`ifdef DIAL_ACCEL_EN
            r_period <= w_period_nxt;
            r_scnt   <= w_scnt_nxt;
`endif
        end
    end

    assign bus.dial   = r_dial;
    assign bus.moving = (r_state == ST_RUN);

endmodule
